// File: rtl/sub24bit_seq.sv
// sub24bit_seq: 24-bit A-B-Bin computed as two chained 12-bit half-steps with flags and valid/ready handshake
module sub24bit_seq #(
  parameter int WIDTH = 24,
  parameter int HALF  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             Bout,
  output logic             ZERO,
  output logic             NEG,
  output logic             OVF
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [HALF-1:0] lo_q;
  logic bin_q, lb;
  logic [HALF:0] lo_sum, hi_sum;
  assign lo_sum = {1'b0, a_q[HALF-1:0]} + {1'b0, ~b_q[HALF-1:0]} + {{HALF{1'b0}}, ~bin_q};
  assign hi_sum = {1'b0, a_q[WIDTH-1:HALF]} + {1'b0, ~b_q[WIDTH-1:HALF]} + {{HALF{1'b0}}, ~lb};
  always_comb begin
    next = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    unique case (state)
      IDLE: next = in_valid ? LOW : IDLE;
      LOW:  next = HIGH;
      HIGH: next = DONE;
      DONE: next = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // The low half is staged in lo_q so DIFF changes only when the full result lands
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      bin_q <= 1'b0;
      lo_q <= '0;
      lb <= 1'b0;
      DIFF <= '0;
      Bout <= 1'b0;
      ZERO <= 1'b0;
      NEG <= 1'b0;
      OVF <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= A;
        b_q <= B;
        bin_q <= Bin;
      end
      if (state == LOW) begin
        lo_q <= lo_sum[HALF-1:0];
        lb <= ~lo_sum[HALF];
      end
      if (state == HIGH) begin
        DIFF <= {hi_sum[HALF-1:0], lo_q};
        Bout <= ~hi_sum[HALF];
        ZERO <= ~|{hi_sum[HALF-1:0], lo_q};
        NEG <= hi_sum[HALF-1];
        OVF <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (hi_sum[HALF-1] ^ a_q[WIDTH-1]);
      end
    end
endmodule

// File: tb/tb_sub24bit_seq.sv
// tb_sub24bit_seq: directed-vector bench for the two-cycle 24-bit subtractor
module tb_sub24bit_seq;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0, Bin = 0;
  logic [23:0] A = '0, B = '0;
  logic in_ready, out_valid, Bout, ZERO, NEG, OVF;
  logic [23:0] DIFF;
  int tests = 0, fails = 0;
  sub24bit_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .DIFF(DIFF), .Bout(Bout), .ZERO(ZERO), .NEG(NEG), .OVF(OVF)
  );
  always #5 clk = ~clk;
  // Accepts one operation, drives junk with in_valid high while busy, returns edges until out_valid
  task automatic op(input logic [23:0] a, input logic [23:0] b, input logic bin, output int n);
    int w = 0;
    while (!in_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    A = a; B = b; Bin = bin; in_valid = 1;
    @(posedge clk); #1;
    A = 24'hABCDEF; B = 24'h13579B; Bin = 1;
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 0;
  endtask
  task automatic release_out;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic check_vec(input logic [23:0] a, input logic [23:0] b, input logic bin,
                           input logic [27:0] exp, input string name);
    int n;
    op(a, b, bin, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL %s latency: got %0d want 2", name, n); end
    tests++;
    if ({DIFF, Bout, ZERO, NEG, OVF} !== exp) begin
      fails++;
      $display("FAIL %s result: got %h/%b%b%b%b want %h/%b", name, DIFF, Bout, ZERO, NEG, OVF, exp[27:4], exp[3:0]);
    end
    release_out;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL %s release: got ready=%b valid=%b want 1 0", name, in_ready, out_valid);
    end
  endtask
  task automatic test_reset;
    #3;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid}); end
    tests++;
    if ({DIFF, Bout, ZERO, NEG, OVF} !== 28'h0) begin fails++; $display("FAIL reset_out: got %h want 0", {DIFF, Bout, ZERO, NEG, OVF}); end
    @(posedge clk); @(posedge clk); #1 reset = 0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL post_reset_hs: got %b want 10", {in_ready, out_valid}); end
  endtask
  task automatic test_basic;
    check_vec(24'h000001, 24'h000002, 0, {24'hFFFFFF, 4'b1010}, "basic_borrow");
    check_vec(24'h001000, 24'h000001, 0, {24'h000FFF, 4'b0000}, "cross_half");
  endtask
  task automatic test_overflow;
    check_vec(24'h800000, 24'h000001, 0, {24'h7FFFFF, 4'b0001}, "ovf_neg_minus_pos");
    check_vec(24'h7FFFFF, 24'hFFFFFF, 0, {24'h800000, 4'b1011}, "ovf_pos_minus_neg");
  endtask
  task automatic test_borrow_in;
    check_vec(24'h123456, 24'h123455, 1, {24'h000000, 4'b0100}, "zero_bin");
    check_vec(24'h000ABC, 24'h000ABC, 1, {24'hFFFFFF, 4'b1010}, "equal_bin");
    check_vec(24'h000ABC, 24'h000ABC, 0, {24'h000000, 4'b0100}, "equal_nobin");
  endtask
  task automatic test_backpressure;
    int n;
    op(24'h000010, 24'h000003, 0, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL bp latency: got %0d want 2", n); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; A = 24'h111111 * i[23:0]; B = 24'h000777; Bin = ~i[0];
      @(posedge clk); #1;
      tests++;
      if ({out_valid, in_ready, DIFF, Bout, ZERO, NEG, OVF} !== {2'b10, 24'h00000D, 4'b0000}) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b r=%b %h/%b%b%b%b want v=1 r=0 00000d/0000", i, out_valid, in_ready, DIFF, Bout, ZERO, NEG, OVF);
      end
    end
    in_valid = 0;
    release_out;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL bp_release: got %b want 10", {in_ready, out_valid}); end
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL bp_no_accept: got %b want 10", {in_ready, out_valid}); end
  endtask
  task automatic test_reset_midop;
    int seen = 0;
    A = 24'h000100; B = 24'h000001; Bin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    reset = 1;
    #1;
    tests++;
    if ({out_valid, DIFF, Bout, ZERO, NEG, OVF} !== 29'h0) begin
      fails++; $display("FAIL midop_reset_out: got %h want 0", {out_valid, DIFF, Bout, ZERO, NEG, OVF});
    end
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL midop_no_valid: got %0d pulses want 0", seen); end
    tests++;
    if ({in_ready, DIFF} !== {1'b1, 24'h0}) begin fails++; $display("FAIL midop_idle: got %b/%h want 1/000000", in_ready, DIFF); end
    check_vec(24'h000005, 24'h000003, 0, {24'h000002, 4'b0000}, "after_reset");
  endtask
  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_borrow_in;
    test_backpressure;
    test_reset_midop;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
